// File: rtl/pixel_stream_bridge_if.sv
// pixel_stream_bridge_if: UART RX, Edge filter and UART TX signal bundle for pixel_stream_bridge
interface pixel_stream_bridge_if #(parameter int DEPTH = 16);
  logic rx_recieved;
  logic [7:0] rx_data;
  logic px_en;
  logic [7:0] px_in;
  logic [7:0] px_out;
  logic tx_transmit;
  logic [7:0] tx_data;
  logic tx_busy;
  logic [$clog2(DEPTH):0] fifo_level;
  logic overflow;
  modport master(output rx_recieved, rx_data, px_out, tx_busy,
                 input px_en, px_in, tx_transmit, tx_data, fifo_level, overflow);
  modport slave(input rx_recieved, rx_data, px_out, tx_busy,
                output px_en, px_in, tx_transmit, tx_data, fifo_level, overflow);
endinterface

// File: rtl/pixel_stream_bridge.sv
// pixel_stream_bridge: UART RX -> Edge -> result FIFO -> UART TX glue.
// Define PIXEL_BRIDGE_LOOPBACK_EN to bypass Edge and echo raw RX bytes.
module pixel_stream_bridge #(
  parameter int DEPTH = 16,
  parameter int EDGE_LAT = 1
) (
  input logic clk,
  input logic rst_n,
  pixel_stream_bridge_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {TX_IDLE, TX_WAIT_BUSY, TX_WAIT_DONE} state_t;
  state_t state, state_nx;
  logic rx_q, new_byte, en, push, accept, full, pop, overflow, tx;
  logic [7:0] pix, push_data, txd;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] level;
  logic [3:0] tmo;
  // rx_q resets high so a byte already flagged at reset release is ignored
  assign new_byte = bus.rx_recieved & ~rx_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      rx_q <= 1'b1;
      en <= 1'b0;
      pix <= 8'd0;
    end else begin
      rx_q <= bus.rx_recieved;
      en <= new_byte;
      pix <= new_byte ? bus.rx_data : pix;
    end
`ifdef PIXEL_BRIDGE_LOOPBACK_EN
  assign push = en;
  assign push_data = pix;
  assign bus.px_en = 1'b0;
`else
  logic [EDGE_LAT-1:0] lat;
  always_ff @(posedge clk) lat <= !rst_n ? '0 : (lat << 1) | EDGE_LAT'(en);
  assign push = lat[EDGE_LAT-1];
  assign push_data = bus.px_out;
  assign bus.px_en = en;
`endif
  assign full = level == (AW+1)'(DEPTH);
  assign accept = push & (~full | pop);
  always_ff @(posedge clk) if (accept) mem[wp] <= push_data;
  always_ff @(posedge clk)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
      overflow <= 1'b0;
    end else begin
      wp <= wp + AW'(accept);
      rp <= rp + AW'(pop);
      level <= level + (AW+1)'(accept) - (AW+1)'(pop);
      overflow <= overflow | (push & ~accept);
    end
  always_ff @(posedge clk) state <= !rst_n ? TX_IDLE : state_nx;
  always_comb
    state_nx = state == TX_IDLE ? (pop ? TX_WAIT_BUSY : TX_IDLE)
             : state == TX_WAIT_BUSY ? (bus.tx_busy ? TX_WAIT_DONE : tmo == 4'd14 ? TX_IDLE : TX_WAIT_BUSY)
             : bus.tx_busy ? TX_WAIT_DONE : TX_IDLE;
  always_comb pop = state == TX_IDLE && level != '0 && !bus.tx_busy;
  // a TX that never reports busy is treated as done after 15 cycles
  always_ff @(posedge clk) tmo <= (!rst_n || state != TX_WAIT_BUSY) ? 4'd0 : tmo + 4'd1;
  always_ff @(posedge clk)
    if (!rst_n) begin
      tx <= 1'b0;
      txd <= 8'd0;
    end else begin
      tx <= pop;
      txd <= pop ? mem[rp] : txd;
    end
  assign bus.px_in = pix;
  assign bus.tx_transmit = tx;
  assign bus.tx_data = txd;
  assign bus.fifo_level = level;
  assign bus.overflow = overflow;
endmodule

// File: tb/tb_pixel_stream_bridge.sv
// tb_pixel_stream_bridge: randomized bench with a queue-based reference model of the bridge
module tb_pixel_stream_bridge;
  localparam int DEPTH = 16;
  localparam int LAT = 1;
`ifdef PIXEL_BRIDGE_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif
  localparam int PUSH_D = LB ? 1 : LAT + 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;
  pixel_stream_bridge_if #(.DEPTH(DEPTH)) bus();
  pixel_stream_bridge #(.DEPTH(DEPTH), .EDGE_LAT(LAT)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  int errors = 0, checks = 0;
  int cyc = 0, mode = 0, bcnt = 0, tx_cnt = 0, pxen_cnt = 0;
  logic [7:0] txlog[$];
  logic [7:0] mq[$];
  int pt[$];
  logic [7:0] pd[$];
  logic m_rxq = 1'b1, m_ov = 1'b0, m_idle = 1'b1, m_seen = 1'b0;
  logic e_pxen = 1'b0, e_tx = 1'b0, nw, pop;
  logic [7:0] e_pxin = 8'd0, e_txd = 8'd0;
  int m_cnt = 0;
  function automatic logic [7:0] f(input logic [7:0] b);
    return LB ? b : ~b;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  // reference model: FIFO as a queue, pushes scheduled by arrival time, TX as a wait protocol
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      mq.delete(); pt.delete(); pd.delete();
      m_rxq = 1'b1; m_ov = 1'b0; m_idle = 1'b1; m_seen = 1'b0; m_cnt = 0;
      e_pxen = 1'b0; e_pxin = 8'd0; e_tx = 1'b0; e_txd = 8'd0;
    end else begin
      nw = bus.rx_recieved & ~m_rxq;
      m_rxq = bus.rx_recieved;
      pop = m_idle && mq.size() != 0 && !bus.tx_busy;
      e_tx = pop;
      if (pop) begin
        e_txd = mq.pop_front();
        m_idle = 1'b0; m_seen = 1'b0; m_cnt = 0;
      end else if (!m_idle) begin
        if (m_seen) m_idle = !bus.tx_busy;
        else if (bus.tx_busy) m_seen = 1'b1;
        else begin
          m_cnt++;
          m_idle = m_cnt == 15;
        end
      end
      if (pt.size() != 0 && pt[0] == cyc) begin
        void'(pt.pop_front());
        if (mq.size() < DEPTH) mq.push_back(pd.pop_front());
        else begin
          void'(pd.pop_front());
          m_ov = 1'b1;
        end
      end
      if (nw) begin
        pt.push_back(cyc + PUSH_D);
        pd.push_back(f(bus.rx_data));
        e_pxin = bus.rx_data;
      end
      e_pxen = nw & ~LB;
    end
  end
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("px_en", bus.px_en, e_pxen);
      chk("px_in", bus.px_in, e_pxin);
      chk("tx_transmit", bus.tx_transmit, e_tx);
      chk("tx_data", bus.tx_data, e_txd);
      chk("fifo_level", bus.fifo_level, mq.size());
      chk("overflow", bus.overflow, m_ov);
    end
  end
  // one cycle of environment: Edge model (~x) and UART TX busy responder
  task automatic tick();
    @(negedge clk);
    if (bus.px_en) begin
      bus.px_out = ~bus.px_in;
      pxen_cnt++;
    end
    if (bus.tx_transmit) begin
      tx_cnt++;
      txlog.push_back(bus.tx_data);
      if (mode == 0) bcnt = $urandom_range(1, 5);
    end
    bus.tx_busy = mode == 1 ? 1'b1 : mode == 2 ? 1'b0 : bcnt > 0;
    if (bcnt > 0) bcnt--;
  endtask
  task automatic send(input logic [7:0] b);
    tick();
    bus.rx_data = b;
    bus.rx_recieved = 1'b1;
    tick();
    bus.rx_recieved = 1'b0;
  endtask
  task automatic wait_tx(input int lim, input string nm);
    int n0 = tx_cnt;
    for (int k = 0; k < lim && tx_cnt == n0; k++) tick();
    chk(nm, tx_cnt != n0, 1);
  endtask
  task automatic drain(input string nm);
    for (int k = 0; k < 600 && bus.fifo_level != 0; k++) tick();
    repeat (20) tick();
    chk(nm, bus.fifo_level, 0);
  endtask
  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  initial begin
    int n0, t0;
    bus.rx_recieved = 1'b1;
    bus.rx_data = 8'h11;
    bus.px_out = 8'd0;
    bus.tx_busy = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("held_rx_level", bus.fifo_level, 0);
    chk("held_rx_pxen", pxen_cnt, 0);
    bus.rx_recieved = 1'b0;
    tick();
    send(8'h5A);
    wait_tx(20, "first_tx_timeout");
    chk("first_tx_data", bus.tx_data, LB ? 8'h5A : 8'hA5);
    repeat (10) tick();
    chk("single_tx", tx_cnt, 1);
    chk("single_pxen", pxen_cnt, LB ? 0 : 1);
    mode = 1;
    tick();
    n0 = tx_cnt;
    for (int i = 0; i < 16; i++) send(8'h30 + 8'(i));
    repeat (6) tick();
    chk("fill_level", bus.fifo_level, 16);
    chk("fill_overflow", bus.overflow, 0);
    send(8'hEE);
    repeat (6) tick();
    chk("ovf_level", bus.fifo_level, 16);
    chk("ovf_flag", bus.overflow, 1);
    mode = 0;
    drain("drain1_empty");
    chk("drain1_count", tx_cnt - n0, 16);
    chk("drain1_first", txlog[n0], f(8'h30));
    chk("drain1_last", txlog[n0 + 15], f(8'h3F));
    do_reset();
    mode = 1;
    tick();
    for (int i = 0; i < 16; i++) send(8'h80 + 8'(i));
    repeat (6) tick();
    tick();
    bus.rx_data = 8'hC3;
    bus.rx_recieved = 1'b1;
    for (int d = 1; d <= PUSH_D; d++) begin
      tick();
      bus.rx_recieved = 1'b0;
      if (d == PUSH_D) begin
        mode = 0;
        bus.tx_busy = 1'b0;
      end
    end
    n0 = tx_cnt;
    tick();
    chk("pushpop_level", bus.fifo_level, 16);
    chk("pushpop_overflow", bus.overflow, 0);
    chk("pushpop_tx", tx_cnt - n0, 1);
    drain("drain2_empty");
    chk("drain2_last", txlog[txlog.size() - 1], f(8'hC3));
    do_reset();
    mode = 2;
    tick();
    send(8'h01);
    send(8'h02);
    wait_tx(20, "tmo_first");
    t0 = cyc;
    wait_tx(40, "tmo_second");
    chk("tmo_gap", cyc - t0, 16);
    chk("tmo_data", bus.tx_data, f(8'h02));
    do_reset();
    mode = 1;
    tick();
    for (int i = 0; i < 8; i++) send(8'h40 + 8'(i));
    repeat (6) tick();
    mode = 0;
    for (int k = 0; k < 300 && bus.fifo_level != 5; k++) tick();
    chk("mid_level5", bus.fifo_level, 5);
    rst_n = 1'b0;
    n0 = tx_cnt;
    tick();
    chk("rst_level", bus.fifo_level, 0);
    chk("rst_tx", bus.tx_transmit, 0);
    rst_n = 1'b1;
    repeat (40) tick();
    chk("rst_no_tx", tx_cnt - n0, 0);
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst_n = $urandom_range(0, 699) != 0;
      if ($urandom_range(0, 149) == 0) mode = $urandom_range(0, 2);
      if (!bus.rx_recieved) bus.rx_data = 8'($urandom);
      bus.rx_recieved = $urandom_range(0, 2) != 0;
    end
    rst_n = 1'b1;
    bus.rx_recieved = 1'b0;
    mode = 0;
    drain("final_empty");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pixel_stream_bridge.md
# pixel_stream_bridge

Byte-stream glue between the UART and the Edge pixel filter. Detects each newly received UART byte, presents it to Edge with a one-cycle enable, captures Edge's result a fixed latency later into a small FIFO, and drains the FIFO to the UART transmitter under its busy handshake. It replaces the ad-hoc received/transmit edge logic in the top level and decouples Edge output from UART TX throughput.

## Interface
Parameters:
- DEPTH, 16, result FIFO entries; power of two, 2..256
- EDGE_LAT, 1, cycles from px_en high to valid px_out; 1..8

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- rx_recieved  in  1  UART RX byte-available level; a rising edge marks a new byte
- rx_data  in  8  UART RX byte; stable while rx_recieved high
- px_en  out  1  one-cycle enable to Edge (en)
- px_in  out  8  pixel to Edge (PixelIn)
- px_out  in  8  Edge result (PixelOut)
- tx_transmit  out  1  one-cycle start pulse to UART TX
- tx_data  out  8  byte to UART TX; held until next start
- tx_busy  in  1  UART TX busy
- fifo_level  out  log2(DEPTH)+1  FIFO occupancy, 0..DEPTH
- overflow  out  1  sticky: a result was dropped on a full FIFO

## Operation
- Reset values: px_en 0, px_in 0, tx_transmit 0, tx_data 0, fifo_level 0, overflow 0, state TX_IDLE, rx edge register 1 (a byte already flagged at reset release is not consumed).
- RX detect: rx_q <= rx_recieved each cycle; new = rx_recieved & ~rx_q.
- Cycle after new: px_en=1, px_in=rx_data (registered). Otherwise px_en=0, px_in holds.
- EDGE_LAT-bit shift register tracks px_en; when its output is 1, px_out is pushed.
- FIFO: circular, read/write pointers wrap at DEPTH. Push is accepted when not full, or when full with a pop in the same cycle. Otherwise the push is dropped and overflow=1 until reset. Pop on empty never occurs.
- fifo_level = pushes − pops; updates the cycle after the event; a simultaneous accepted push and pop leaves it unchanged.
- TX FSM:
  - TX_IDLE: if level≠0 and tx_busy=0 → tx_data<=head, tx_transmit=1 for one cycle, pop; go TX_WAIT_BUSY.
  - TX_WAIT_BUSY: tx_busy=1 → TX_WAIT_DONE; 15 cycles without busy → TX_IDLE (timeout, byte counted as sent).
  - TX_WAIT_DONE: tx_busy=0 → TX_IDLE.
- Synchronous reset mid-operation clears the FIFO, the pipeline and the FSM on the next edge. In-flight Edge results are discarded.

## Timing
- RX byte edge sampled at cycle N → px_en high at N+1 → push at N+1+EDGE_LAT → fifo_level increments at N+2+EDGE_LAT.
- Pop from TX_IDLE with non-empty FIFO: tx_transmit high one cycle after level≠0 is visible; tx_data valid in the same cycle as tx_transmit.
- Minimum spacing between tx_transmit pulses: 3 cycles (IDLE, WAIT_BUSY, WAIT_DONE).
- Back-to-back RX edges every 2 cycles are supported. The enable pipeline handles one new byte per cycle.

## Configuration
- PIXEL_BRIDGE_LOOPBACK_EN defined: the Edge path is bypassed. px_en stays 0. rx_data is pushed into the FIFO the cycle after new, so the UART echoes raw bytes. EDGE_LAT is ignored.
- Undefined: normal path through Edge as described above.

## Test plan
- Reset with rx_recieved=1 held → no px_en; then drop rx_recieved and raise it with 0x5A → one px_en with px_in=0x5A, and px_out (model Edge=~x) 0xA5 appears on tx_data with a single tx_transmit.
- tx_busy held 1 while 16 bytes arrive → fifo_level reaches 16, overflow=0; 17th byte → overflow=1, level stays 16; release busy → 16 bytes transmitted in order.
- Full FIFO, push and pop in the same cycle → push accepted, level stays 16, overflow stays 0.
- tx_busy never rises after tx_transmit → FSM returns to TX_IDLE after 15 cycles and sends the next byte.
- rst_n low mid-drain with level=5 → next cycle level=0, tx_transmit=0, state TX_IDLE; no further transmits.
- PIXEL_BRIDGE_LOOPBACK_EN build: bytes 0x00, 0xFF, 0x3C → echoed unchanged in order, px_en never asserted.
